// File: rtl/traffic_light_fsm.sv
// Two-way intersection controller: NS/EW green-yellow-allred sequencing, pedestrian
// walk insertion and flashing-yellow fallback, timed by edges of the divider's 1 Hz output.
module traffic_light_fsm #(
  parameter int unsigned T_GREEN  = 20,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 8
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [5:0] sec_left
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED1  = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED2  = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  localparam logic [5:0] LD_GREEN  = 6'(T_GREEN - 1);
  localparam logic [5:0] LD_YELLOW = 6'(T_YELLOW - 1);
  localparam logic [5:0] LD_ALLRED = 6'(T_ALLRED - 1);
  localparam logic [5:0] LD_WALK   = 6'(T_WALK - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  state_t     state_q, state_d;
  logic [5:0] timer_q, timer_d;
  logic       phase_q, phase_d;
  logic       ped_pending_q, ped_pending_d;
  logic [2:0] sync_q, sync_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       tick;

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect delay stage
  always_comb begin
    sync_d = {sync_q[1:0], clk_1Hz};
    tick   = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    phase_d       = phase_q;
    ped_pending_d = ped_pending_q;

    if (!enable) begin
      state_d       = FLASH;
      ped_pending_d = 1'b0;
      if (state_q != FLASH) begin
        phase_d = 1'b1;
      end else if (tick) begin
        phase_d = ~phase_q;
      end
    end else if (state_q == FLASH) begin
      // leave flashing through all-red so no approach sees green abruptly
      state_d = RED2;
      timer_d = LD_ALLRED;
      phase_d = 1'b1;
    end else begin
      if (ped_req) begin
        ped_pending_d = 1'b1;
      end
      if (tick) begin
        if (timer_q == 6'd0) begin
          case (state_q)
            NS_G: begin
              state_d = NS_Y;
              timer_d = LD_YELLOW;
            end
            NS_Y: begin
              state_d = RED1;
              timer_d = LD_ALLRED;
            end
            RED1: begin
              state_d = EW_G;
              timer_d = LD_GREEN;
            end
            EW_G: begin
              state_d = EW_Y;
              timer_d = LD_YELLOW;
            end
            EW_Y: begin
              state_d = RED2;
              timer_d = LD_ALLRED;
            end
            RED2: begin
              if (ped_pending_q) begin
                state_d       = WALK;
                timer_d       = LD_WALK;
                ped_pending_d = 1'b0;
              end else begin
                state_d = NS_G;
                timer_d = LD_GREEN;
              end
            end
            WALK: begin
              state_d = NS_G;
              timer_d = LD_GREEN;
            end
            default: begin
              state_d = RED2;
              timer_d = LD_ALLRED;
            end
          endcase
        end else begin
          timer_d = timer_q - 6'd1;
        end
      end
    end
  end

  // lamps are decoded from the next state so they register on the same edge as it
  always_comb begin
    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      NS_G:  ns_d = LAMP_GREEN;
      NS_Y:  ns_d = LAMP_YELLOW;
      EW_G:  ew_d = LAMP_GREEN;
      EW_Y:  ew_d = LAMP_YELLOW;
      WALK:  walk_d = 1'b1;
      FLASH: begin
        ns_d = phase_d ? LAMP_YELLOW : LAMP_OFF;
        ew_d = phase_d ? LAMP_YELLOW : LAMP_OFF;
      end
      default: begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q       <= RED2;
      timer_q       <= LD_ALLRED;
      phase_q       <= 1'b1;
      ped_pending_q <= 1'b0;
      ns_q          <= LAMP_RED;
      ew_q          <= LAMP_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      phase_q       <= phase_d;
      ped_pending_q <= ped_pending_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign ped_walk = walk_q;
  assign sec_left = timer_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: a phase-level model pushes expected lamp/timer
// values as each 1 Hz period is driven; they are popped and compared once the tick has landed.
module tb_traffic_light_fsm;

  localparam int T_GREEN  = 20;
  localparam int T_YELLOW = 3;
  localparam int T_ALLRED = 1;
  localparam int T_WALK   = 8;

  localparam int S_NS_G  = 0;
  localparam int S_NS_Y  = 1;
  localparam int S_RED1  = 2;
  localparam int S_EW_G  = 3;
  localparam int S_EW_Y  = 4;
  localparam int S_RED2  = 5;
  localparam int S_WALK  = 6;
  localparam int S_FLASH = 7;

  logic       clk_100MHz = 1'b0;
  logic       rst;
  logic       clk_1Hz;
  logic       enable;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic [5:0] sec_left;

  typedef struct {
    string       tag;
    logic [12:0] val;
    bit          maskSec;
  } expEntry_t;

  expEntry_t expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;

  int mState;
  int mTimer;
  bit mPending;
  bit mPhase;

  traffic_light_fsm #(
    .T_GREEN (T_GREEN),
    .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED),
    .T_WALK  (T_WALK)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst       (rst),
    .clk_1Hz   (clk_1Hz),
    .enable    (enable),
    .ped_req   (ped_req),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ped_walk  (ped_walk),
    .sec_left  (sec_left)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic int phaseLen(input int s);
    case (s)
      S_NS_G, S_EW_G: return T_GREEN;
      S_NS_Y, S_EW_Y: return T_YELLOW;
      S_RED1, S_RED2: return T_ALLRED;
      S_WALK:         return T_WALK;
      default:        return 1;
    endcase
  endfunction

  function automatic int nextPhase(input int s, input bit pend);
    case (s)
      S_NS_G:  return S_NS_Y;
      S_NS_Y:  return S_RED1;
      S_RED1:  return S_EW_G;
      S_EW_G:  return S_EW_Y;
      S_EW_Y:  return S_RED2;
      S_RED2:  return pend ? S_WALK : S_NS_G;
      default: return S_NS_G;
    endcase
  endfunction

  // model reaction to one tick
  task automatic modelTick();
    if (mState == S_FLASH) begin
      mPhase = ~mPhase;
    end else if (mTimer == 0) begin
      mState = nextPhase(mState, mPending);
      mTimer = phaseLen(mState) - 1;
      if (mState == S_WALK) mPending = 1'b0;
    end else begin
      mTimer = mTimer - 1;
    end
  endtask

  function automatic logic [12:0] expectedVal();
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic [5:0] sec;
    ns   = 3'b100;
    ew   = 3'b100;
    walk = 1'b0;
    sec  = 6'(mTimer);
    case (mState)
      S_NS_G:  ns = 3'b001;
      S_NS_Y:  ns = 3'b010;
      S_EW_G:  ew = 3'b001;
      S_EW_Y:  ew = 3'b010;
      S_WALK:  walk = 1'b1;
      S_FLASH: begin
        ns  = mPhase ? 3'b010 : 3'b000;
        ew  = mPhase ? 3'b010 : 3'b000;
        sec = 6'd0;
      end
      default: ;
    endcase
    return {ns, ew, walk, sec};
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] observed, input logic [12:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got ns/ew/walk/sec=%b/%b/%b/%0d, expected %b/%b/%b/%0d at %0t",
               tag, observed[12:10], observed[9:7], observed[6], observed[5:0],
               expected[12:10], expected[9:7], expected[6], expected[5:0], $time);
    end
  endtask

  task automatic pushExpected(input string tag);
    expEntry_t e;
    e.tag     = tag;
    e.val     = expectedVal();
    e.maskSec = (mState == S_FLASH);
    expQ.push_back(e);
  endtask

  task automatic popAndCheck();
    expEntry_t e;
    logic [12:0] obs;
    if (expQ.size() != 0) begin
      e   = expQ.pop_front();
      obs = {ns_light, ew_light, ped_walk, e.maskSec ? 6'd0 : sec_left};
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  // one clk_1Hz period: high for highCycles, low for 10; exactly one tick expected
  task automatic applyStimulus(input int highCycles, input string tag);
    modelTick();
    pushExpected(tag);
    @(negedge clk_100MHz);
    clk_1Hz = 1'b1;
    repeat (highCycles) @(negedge clk_100MHz);
    clk_1Hz = 1'b0;
    repeat (10) @(negedge clk_100MHz);
    popAndCheck();
  endtask

  task automatic runTicks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(10, $sformatf("%s_%0d", tag, i));
    end
  endtask

  task automatic pulsePed();
    @(negedge clk_100MHz);
    ped_req = 1'b1;
    @(negedge clk_100MHz);
    ped_req = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    clk_1Hz  = 1'b0;
    enable   = 1'b1;
    ped_req  = 1'b0;
    mState   = S_RED2;
    mTimer   = T_ALLRED - 1;
    mPending = 1'b0;
    mPhase   = 1'b1;

    repeat (3) @(negedge clk_100MHz);
    pushExpected("during_reset");
    popAndCheck();
    rst = 1'b0;

    applyStimulus(10, "first_tick");
    runTicks(48, "full_cycle");

    runTicks(24, "to_ew_g");
    pulsePed();
    mPending = 1'b1;
    runTicks(32, "ped_walk");
    runTicks(48, "skip_walk");

    runTicks(9, "to_ns_g10");
    @(negedge clk_100MHz);
    enable   = 1'b0;
    mState   = S_FLASH;
    mPhase   = 1'b1;
    mPending = 1'b0;
    pushExpected("flash_entry");
    @(posedge clk_100MHz);
    #1;
    popAndCheck();
    pulsePed();
    runTicks(4, "flash_toggle");
    @(negedge clk_100MHz);
    enable = 1'b1;
    mState = S_RED2;
    mTimer = T_ALLRED - 1;
    pushExpected("flash_exit");
    @(posedge clk_100MHz);
    #1;
    popAndCheck();
    applyStimulus(10, "after_flash");

    runTicks(44, "to_ew_y");
    pulsePed();
    @(posedge clk_100MHz);
    #3;
    rst      = 1'b1;
    mState   = S_RED2;
    mTimer   = T_ALLRED - 1;
    mPending = 1'b0;
    pushExpected("async_reset");
    #1;
    popAndCheck();
    repeat (2) @(negedge clk_100MHz);
    rst = 1'b0;
    runTicks(49, "after_reset");

    applyStimulus(50, "long_high");
    applyStimulus(10, "after_long_high");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Two-way intersection controller that sits directly downstream of `clk_divider`. Consumes its `clk_1Hz` output as a timing reference, sampled and edge-detected in the `clk_100MHz` domain; the divider output is never used as a clock here. Sequences north-south and east-west lamps through green, yellow and all-red phases, inserts a pedestrian walk phase on request, and falls back to flashing yellow when disabled.

## Interface
- `T_GREEN`, default 20: green duration in ticks (legal range 1..63, all `T_*`)
- `T_YELLOW`, default 3: yellow duration in ticks
- `T_ALLRED`, default 1: all-red clearance in ticks
- `T_WALK`, default 8: pedestrian walk duration in ticks

- `clk_100MHz`  in  1  system clock; the only clock
- `rst`  in  1  asynchronous, active-high reset
- `clk_1Hz`  in  1  divider output, treated as asynchronous data
- `enable`  in  1  1 = normal sequencing; 0 = flashing-yellow mode
- `ped_req`  in  1  pedestrian button, level or pulse, synchronous to `clk_100MHz`
- `ns_light`  out  3  north-south lamps {red, yellow, green}, one-hot or 000
- `ew_light`  out  3  east-west lamps {red, yellow, green}
- `ped_walk`  out  1  walk lamp
- `sec_left`  out  6  ticks remaining in the current phase, minus one

## Operation
- Tick generation:
  - `clk_1Hz` passes through a 2-flop synchronizer, then a third flop.
  - `tick` = sync2 & ~sync3, exactly one `clk_100MHz` cycle wide per rising edge of `clk_1Hz`.
- States: NS_G, NS_Y, RED1, EW_G, EW_Y, RED2, WALK, FLASH.
- Lamp outputs per state (registered):
  - NS_G: ns=001, ew=100
  - NS_Y: ns=010, ew=100
  - RED1, RED2, WALK: ns=100, ew=100
  - EW_G: ns=100, ew=001
  - EW_Y: ns=100, ew=010
  - FLASH: ns=ew=010 when phase=1, otherwise 000
  - `ped_walk`=1 only in WALK.
- Timer (6-bit):
  - Loaded with T_x−1 on entry to a state.
  - On `tick`: if timer==0, transition; else decrement.
  - Each timed state therefore lasts exactly T_x ticks. `sec_left` = timer.
- Sequence: NS_G→NS_Y→RED1→EW_G→EW_Y→RED2→(WALK if ped_pending, else NS_G); WALK→NS_G.
- Pedestrian request:
  - `ped_pending` is set on any cycle with `ped_req`=1.
  - Cleared on the cycle WALK is entered.
  - A request arriving during WALK sets it again, giving one more WALK on the next cycle round.
  - When set and entry into WALK coincide, the clear wins.
- Flashing mode:
  - `enable`=0 in any state forces FLASH on the next clock edge, ignoring the timer.
  - `ped_pending` is cleared; `ped_req` is ignored while in FLASH.
  - Entry sets phase=1; phase toggles on each `tick`.
  - `enable` returning to 1 moves FLASH→RED2 with timer=T_ALLRED−1, so lamps resume from all-red.
- Priority per cycle: `rst` > `enable`=0 > timer transition > decrement.

## Timing
- Reset values:
  - state=RED2, timer=T_ALLRED−1
  - ns_light=100, ew_light=100, ped_walk=0, sec_left=T_ALLRED−1
  - ped_pending=0, sync flops=0, phase=1
- `rst` deasserting during a high `clk_1Hz` produces one tick about 3 cycles later, because sync3 resets to 0. This is accepted.
- Tick latency: `tick` is high in the cycle after the 2nd `clk_100MHz` rising edge following a `clk_1Hz` rise. State, timer and outputs update on the 3rd edge.
- All outputs are registered and change on the same edge as the state.
- `enable` fall to FLASH outputs: 1 clock. No synchronizer on `enable` or `ped_req`; both are synchronous inputs.
- Minimum `clk_1Hz` high and low time: 3 `clk_100MHz` cycles. Each rising edge yields exactly one tick.

## Test plan
- Reset and first ticks: pulse `rst`, drive `clk_1Hz` with a 20-cycle period.
  - During reset, outputs are 100/100/0.
  - After 1 tick (T_ALLRED=1): NS_G, ns=001, sec_left=19.
- Full cycle, defaults, no request: states last 20/3/1/20/3/1 ticks and return to NS_G. `ped_walk` is never 1.
- Pedestrian request: pulse `ped_req` for 1 cycle during EW_G.
  - After RED2, WALK lasts 8 ticks with ped_walk=1 and ns=ew=100, then NS_G.
  - The next round skips WALK.
- Flash: drop `enable` mid-NS_G with sec_left=10.
  - Next clock: ns=ew=010. Lamps toggle to 000 and back on each tick.
  - Raise `enable`: RED2 for 1 tick, then NS_G.
- Async reset mid-phase: assert `rst` between clock edges during EW_Y.
  - Outputs go to 100/100 immediately, without waiting for a clock edge. `ped_pending` is cleared.
- Tick shaping: hold `clk_1Hz` high for 50 cycles. Exactly one tick occurs, and the timer decrements by exactly 1.
